// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arb_pkg
// Brief    : Shared types for the register-file write-port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 32;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        SEL_IDLE       = 2'd0,
        SEL_WB         = 2'd1,
        SEL_MDU        = 2'd2,
        SEL_MDU_FORCED = 2'd3
    } port_sel_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_fifo
// Brief    : Small write-request FIFO with combinational head and a
//            two-way destination lookup across all live entries.
// Revision : 1.0  initial release
// ============================================================================
module regfile_wr_fifo #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_rd,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_rd,
    output logic [DATA_W-1:0] o_head_data,
    input  logic [ADDR_W-1:0] i_q_a,
    input  logic [ADDR_W-1:0] i_q_b,
    output logic              o_hit_a,
    output logic              o_hit_b
);
    import regfile_arb_pkg::*;

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [ADDR_W-1:0]  r_rd   [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [DEPTH-1:0]   w_vld_nxt;
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;

    assign o_full      = &r_vld;
    assign o_empty     = ~|r_vld;
    assign o_head_rd   = r_rd[r_rp];
    assign o_head_data = r_data[r_rp];

    // Clear before set so a full-FIFO push into the slot being popped survives.
    always_comb begin
        w_vld_nxt = r_vld;
        if (i_pop)
            w_vld_nxt[r_rp] = 1'b0;
        if (i_push)
            w_vld_nxt[r_wp] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (i_push)
                r_wp <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
            if (i_pop)
                r_rp <= (r_rp == c_LAST) ? '0 : r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rd[r_wp]   <= i_push_rd;
            r_data[r_wp] <= i_push_data;
        end
    end

    always_comb begin
        o_hit_a = 1'b0;
        o_hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] == i_q_a))
                o_hit_a = 1'b1;
            if (r_vld[i] && (r_rd[i] == i_q_b))
                o_hit_b = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Shares the register-file write port between WB and the MDU,
//            buffers MDU results, tracks pending MDU destinations and bounds
//            how long a buffered result may be starved by WB.
//            ARB_MDU_BYPASS_EN: write an accepted MDU result in its accept
//            cycle when the port is otherwise free.
// Revision : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W       = regfile_arb_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W       = regfile_arb_pkg::DEFAULT_ADDR_W,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] q_rs,
    input  logic [ADDR_W-1:0] q_rt,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic              stall_req,
    output logic              rf_Regwr,
    output logic [ADDR_W-1:0] rf_Rw,
    output logic [DATA_W-1:0] rf_Bw
);
    import regfile_arb_pkg::*;

    localparam int                 c_NREG    = 2 ** ADDR_W;
    localparam int                 c_STV_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);

    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_head_rd;
    logic [DATA_W-1:0] w_head_data;
    logic              w_hit_rs;
    logic              w_hit_rt;

    logic [c_NREG-1:0]  r_pending;
    logic [c_NREG-1:0]  w_pending_nxt;
    logic [c_STV_W-1:0] r_starve;
    logic [ADDR_W-1:0]  r_last_rw;
    logic [DATA_W-1:0]  r_last_bw;

    port_sel_t         w_sel;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_accept;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_clr_en;
    logic              w_wb_req;
    logic              w_starved;

    // Reset gates ready and the WB request directly so nothing reaches the port while held.
    assign mdu_ready = reset & ~w_full;
    assign w_accept  = mdu_valid & mdu_ready & (mdu_rd != '0);
    assign w_wb_req  = reset & wb_we & (wb_rd != '0);
    assign w_starved = ~w_empty & (r_starve == c_STV_MAX);

`ifdef ARB_MDU_BYPASS_EN
    assign w_bypass = w_accept & w_empty & ~w_wb_req;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_sel      = SEL_IDLE;
        w_sel_rd   = r_last_rw;
        w_sel_data = r_last_bw;
        if (w_starved) begin
            w_sel      = SEL_MDU_FORCED;
            w_sel_rd   = w_head_rd;
            w_sel_data = w_head_data;
        end else if (w_wb_req) begin
            w_sel      = SEL_WB;
            w_sel_rd   = wb_rd;
            w_sel_data = wb_data;
        end else if (!w_empty) begin
            w_sel      = SEL_MDU;
            w_sel_rd   = w_head_rd;
            w_sel_data = w_head_data;
        end else if (w_bypass) begin
            w_sel      = SEL_MDU;
            w_sel_rd   = mdu_rd;
            w_sel_data = mdu_data;
        end
    end

    assign w_clr_en  = (w_sel == SEL_MDU) || (w_sel == SEL_MDU_FORCED);
    assign w_pop     = w_clr_en & ~w_empty;
    assign w_push    = w_accept & ~w_bypass;

    assign rf_Regwr  = (w_sel != SEL_IDLE);
    assign rf_Rw     = w_sel_rd;
    assign rf_Bw     = w_sel_data;
    assign stall_req = (w_sel == SEL_MDU_FORCED);

    // A clear and a set of the same register in one cycle leaves it pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clr_en)
            w_pending_nxt[w_sel_rd] = 1'b0;
        if (iss_valid && (iss_rd != '0))
            w_pending_nxt[iss_rd] = 1'b1;
    end

    assign busy_rs = r_pending[q_rs] | w_hit_rs;
    assign busy_rt = r_pending[q_rt] | w_hit_rt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_starve  <= '0;
            r_last_rw <= '0;
            r_last_bw <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_sel != SEL_IDLE) begin
                r_last_rw <= w_sel_rd;
                r_last_bw <= w_sel_data;
            end
            if (w_empty || w_pop)
                r_starve <= '0;
            else if (r_starve != c_STV_MAX)
                r_starve <= r_starve + 1'b1;
        end
    end

    regfile_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_rd   (mdu_rd),
        .i_push_data (mdu_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .i_q_a       (q_rs),
        .i_q_b       (q_rt),
        .o_hit_a     (w_hit_rs),
        .o_hit_b     (w_hit_rt)
    );

    a_issue_not_pending: assert property (@(posedge clk) disable iff (!reset)
        (iss_valid && (iss_rd != '0)) |-> (!r_pending[iss_rd] || (w_clr_en && (w_sel_rd == iss_rd))));

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wb_we = 1'b0;
    logic [ADDR_W-1:0] wb_rd = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              mdu_valid = 1'b0;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_rd = '0;
    logic [DATA_W-1:0] mdu_data = '0;
    logic              iss_valid = 1'b0;
    logic [ADDR_W-1:0] iss_rd = '0;
    logic [ADDR_W-1:0] q_rs = '0;
    logic [ADDR_W-1:0] q_rt = '0;
    logic              busy_rs;
    logic              busy_rt;
    logic              stall_req;
    logic              rf_Regwr;
    logic [ADDR_W-1:0] rf_Rw;
    logic [DATA_W-1:0] rf_Bw;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W       (DATA_W),
        .ADDR_W       (ADDR_W),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .busy_rs   (busy_rs),
        .busy_rt   (busy_rt),
        .stall_req (stall_req),
        .rf_Regwr  (rf_Regwr),
        .rf_Rw     (rf_Rw),
        .rf_Bw     (rf_Bw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1111_1111;
        tick(); settle();
        checks++; if (rf_Regwr !== 1'b0) begin failures++; $display("FAIL reset_regwr actual=%0h expected=0", rf_Regwr); end
        checks++; if (rf_Rw !== 5'd0) begin failures++; $display("FAIL reset_rw actual=%0h expected=0", rf_Rw); end
        checks++; if (rf_Bw !== 32'd0) begin failures++; $display("FAIL reset_bw actual=%0h expected=0", rf_Bw); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall actual=%0h expected=0", stall_req); end
        checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%0h expected=0", mdu_ready); end
        wb_we = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready actual=%0h expected=1", mdu_ready); end
        checks++; if (rf_Regwr !== 1'b0) begin failures++; $display("FAIL reset_release_regwr actual=%0h expected=0", rf_Regwr); end
    endtask

    task automatic test_wb_only();
        tick();
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        settle();
        checks++; if (rf_Regwr !== 1'b1) begin failures++; $display("FAIL wb_regwr actual=%0h expected=1", rf_Regwr); end
        checks++; if (rf_Rw !== 5'd5) begin failures++; $display("FAIL wb_rw actual=%0h expected=5", rf_Rw); end
        checks++; if (rf_Bw !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wb_bw actual=%0h expected=deadbeef", rf_Bw); end
        tick();
        wb_we = 1'b0;
        settle();
        checks++; if (rf_Regwr !== 1'b0) begin failures++; $display("FAIL idle_regwr actual=%0h expected=0", rf_Regwr); end
        checks++; if (rf_Rw !== 5'd5 || rf_Bw !== 32'hDEAD_BEEF) begin failures++; $display("FAIL idle_hold actual=%0h/%0h expected=5/deadbeef", rf_Rw, rf_Bw); end
    endtask

    task automatic test_mdu_idle();
        tick();
        iss_valid = 1'b1; iss_rd = 5'd7; q_rs = 5'd7;
        settle();
        checks++; if (busy_rs !== 1'b0) begin failures++; $display("FAIL mdu_busy_pre actual=%0h expected=0", busy_rs); end
        tick();
        iss_valid = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
        settle();
        checks++; if (busy_rs !== 1'b1) begin failures++; $display("FAIL mdu_busy_issued actual=%0h expected=1", busy_rs); end
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL mdu_ready actual=%0h expected=1", mdu_ready); end
`ifdef ARB_MDU_BYPASS_EN
        checks++; if (rf_Regwr !== 1'b1 || rf_Rw !== 5'd7 || rf_Bw !== 32'h1234) begin failures++; $display("FAIL mdu_bypass_write actual=%0h/%0h/%0h expected=1/7/1234", rf_Regwr, rf_Rw, rf_Bw); end
`else
        checks++; if (rf_Regwr !== 1'b0) begin failures++; $display("FAIL mdu_accept_nowrite actual=%0h expected=0", rf_Regwr); end
`endif
        tick();
        mdu_valid = 1'b0;
        settle();
`ifdef ARB_MDU_BYPASS_EN
        checks++; if (rf_Regwr !== 1'b0 || busy_rs !== 1'b0) begin failures++; $display("FAIL mdu_bypass_after actual=%0h/%0h expected=0/0", rf_Regwr, busy_rs); end
`else
        checks++; if (rf_Regwr !== 1'b1 || rf_Rw !== 5'd7 || rf_Bw !== 32'h1234) begin failures++; $display("FAIL mdu_write actual=%0h/%0h/%0h expected=1/7/1234", rf_Regwr, rf_Rw, rf_Bw); end
        checks++; if (busy_rs !== 1'b1) begin failures++; $display("FAIL mdu_busy_writecycle actual=%0h expected=1", busy_rs); end
`endif
        tick();
        settle();
        checks++; if (busy_rs !== 1'b0 || rf_Regwr !== 1'b0) begin failures++; $display("FAIL mdu_done actual=%0h/%0h expected=0/0", busy_rs, rf_Regwr); end
    endtask

    task automatic test_conflict();
        logic [ADDR_W-1:0] exp_rw;
        tick();
        for (int k = 0; k <= 6; k++) begin
            wb_we = 1'b1;
            wb_rd = (k == 6) ? 5'd15 : 5'(10 + k);
            wb_data = 32'h100 + 32'(wb_rd);
            mdu_valid = (k == 0);
            mdu_rd = 5'd9; mdu_data = 32'h9999;
            settle();
            exp_rw = (k == 5) ? 5'd9 : wb_rd;
            checks++; if (rf_Rw !== exp_rw) begin failures++; $display("FAIL conflict_rw cycle=%0d actual=%0h expected=%0h", k, rf_Rw, exp_rw); end
            checks++; if (stall_req !== (k == 5)) begin failures++; $display("FAIL conflict_stall cycle=%0d actual=%0h expected=%0h", k, stall_req, (k == 5)); end
            if (k == 5) begin
                checks++; if (rf_Bw !== 32'h9999) begin failures++; $display("FAIL conflict_bw actual=%0h expected=9999", rf_Bw); end
            end
            tick();
        end
        wb_we = 1'b0; mdu_valid = 1'b0;
    endtask

    task automatic test_full();
        wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h2020;
        mdu_valid = 1'b1; mdu_rd = 5'd21; mdu_data = 32'hA1;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL full_ready_1 actual=%0h expected=1", mdu_ready); end
        tick();
        mdu_rd = 5'd22; mdu_data = 32'hA2;
        settle();
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL full_ready_2 actual=%0h expected=1", mdu_ready); end
        tick();
        mdu_rd = 5'd23; mdu_data = 32'hA3;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (mdu_ready !== 1'b0 || rf_Rw !== 5'd20 || stall_req !== 1'b0) begin failures++; $display("FAIL full_hold cycle=%0d actual=%0h/%0h/%0h expected=0/14/0", k, mdu_ready, rf_Rw, stall_req); end
            tick();
        end
        settle();
        checks++; if (mdu_ready !== 1'b0 || rf_Rw !== 5'd21 || rf_Bw !== 32'hA1 || stall_req !== 1'b1) begin failures++; $display("FAIL full_forced actual=%0h/%0h/%0h/%0h expected=0/15/a1/1", mdu_ready, rf_Rw, rf_Bw, stall_req); end
        tick();
        wb_we = 1'b0;
        settle();
        checks++; if (mdu_ready !== 1'b1 || rf_Regwr !== 1'b1 || rf_Rw !== 5'd22) begin failures++; $display("FAIL full_drain_1 actual=%0h/%0h/%0h expected=1/1/16", mdu_ready, rf_Regwr, rf_Rw); end
        tick();
        mdu_valid = 1'b0;
        settle();
        checks++; if (rf_Regwr !== 1'b1 || rf_Rw !== 5'd23 || rf_Bw !== 32'hA3) begin failures++; $display("FAIL full_drain_2 actual=%0h/%0h/%0h expected=1/17/a3", rf_Regwr, rf_Rw, rf_Bw); end
        tick();
        settle();
        checks++; if (rf_Regwr !== 1'b0) begin failures++; $display("FAIL full_drained actual=%0h expected=0", rf_Regwr); end
    endtask

    task automatic test_rd0();
        tick();
        wb_we = 1'b1; wb_rd = 5'd25; wb_data = 32'h2525;
        mdu_valid = 1'b1; mdu_rd = 5'd26; mdu_data = 32'h2626;
        settle();
        checks++; if (rf_Rw !== 5'd25) begin failures++; $display("FAIL rd0_setup_rw actual=%0h expected=19", rf_Rw); end
        tick();
        wb_rd = 5'd0; wb_data = 32'hFFFF;
        mdu_rd = 5'd0; mdu_data = 32'hBAD;
        settle();
        checks++; if (rf_Regwr !== 1'b1 || rf_Rw !== 5'd26 || rf_Bw !== 32'h2626 || stall_req !== 1'b0) begin failures++; $display("FAIL rd0_wb_void actual=%0h/%0h/%0h/%0h expected=1/1a/2626/0", rf_Regwr, rf_Rw, rf_Bw, stall_req); end
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL rd0_mdu_ready actual=%0h expected=1", mdu_ready); end
        tick();
        mdu_valid = 1'b0;
        settle();
        checks++; if (rf_Regwr !== 1'b0 || rf_Rw !== 5'd26) begin failures++; $display("FAIL rd0_mdu_void actual=%0h/%0h expected=0/1a", rf_Regwr, rf_Rw); end
        tick();
        wb_we = 1'b0;
    endtask

    task automatic test_reset_midflight();
        wb_we = 1'b1; wb_rd = 5'd28; wb_data = 32'h2828;
        iss_valid = 1'b1; iss_rd = 5'd3;
        mdu_valid = 1'b1; mdu_rd = 5'd29; mdu_data = 32'h29;
        tick();
        iss_valid = 1'b0;
        mdu_rd = 5'd30; mdu_data = 32'h30;
        tick();
        mdu_valid = 1'b0;
        q_rs = 5'd3; q_rt = 5'd30;
        settle();
        checks++; if (busy_rs !== 1'b1 || busy_rt !== 1'b1 || mdu_ready !== 1'b0 || rf_Rw !== 5'd28) begin failures++; $display("FAIL mid_pre actual=%0h/%0h/%0h/%0h expected=1/1/0/1c", busy_rs, busy_rt, mdu_ready, rf_Rw); end
        reset = 1'b0;
        #1;
        checks++; if (rf_Regwr !== 1'b0 || busy_rs !== 1'b0 || busy_rt !== 1'b0 || mdu_ready !== 1'b0) begin failures++; $display("FAIL mid_in_reset actual=%0h/%0h/%0h/%0h expected=0/0/0/0", rf_Regwr, busy_rs, busy_rt, mdu_ready); end
        tick();
        reset = 1'b1;
        wb_we = 1'b0;
        settle();
        checks++; if (rf_Regwr !== 1'b0 || mdu_ready !== 1'b1 || busy_rs !== 1'b0) begin failures++; $display("FAIL mid_after actual=%0h/%0h/%0h expected=0/1/0", rf_Regwr, mdu_ready, busy_rs); end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_mdu_idle();
        test_conflict();
        test_full();
        test_rd0();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
